// File: rtl/plab5_mcore_mem_acc_resp_tracker_pkg.sv
// Shared memory-message field widths and tracker entry layout for the
// memory access-control response tracker.
package plab5_mcore_mem_acc_resp_tracker_pkg;

    localparam int unsigned MEM_TYPE_NBITS = 3;

    typedef enum logic [MEM_TYPE_NBITS-1:0] {
        MEM_TYPE_READ    = 3'd0,
        MEM_TYPE_WRITE   = 3'd1,
        MEM_TYPE_INIT    = 3'd2,
        MEM_TYPE_AMO_ADD = 3'd3,
        MEM_TYPE_AMO_AND = 3'd4,
        MEM_TYPE_AMO_OR  = 3'd5
    } mem_type_e;

    // The len field encodes the access size in bytes, zero meaning a full word.
    function automatic int unsigned mem_len_nbits(input int unsigned data_nbits);
        return $clog2(data_nbits / 8);
    endfunction

    // Request control is {type, opaque, addr, len}.
    function automatic int unsigned mem_req_cnbits(input int unsigned opaque_nbits,
                                                   input int unsigned addr_nbits,
                                                   input int unsigned data_nbits);
        return MEM_TYPE_NBITS + opaque_nbits + addr_nbits + mem_len_nbits(data_nbits);
    endfunction

    // Response control is {type, opaque, len}.
    function automatic int unsigned mem_resp_cnbits(input int unsigned opaque_nbits,
                                                    input int unsigned data_nbits);
        return MEM_TYPE_NBITS + opaque_nbits + mem_len_nbits(data_nbits);
    endfunction

    // Tracker entry is {deny, sec_level, type, opaque, len}; the low part is a
    // ready-made response control word for locally answered requests.
    function automatic int unsigned trk_entry_nbits(input int unsigned opaque_nbits,
                                                    input int unsigned data_nbits);
        return 2 + mem_resp_cnbits(opaque_nbits, data_nbits);
    endfunction

endpackage

// File: rtl/plab5_mcore_mem_acc_resp_tracker_if.sv
// Generic val/rdy message channel: a control word plus a data word.
// master produces the message, slave consumes it and drives rdy.
interface plab5_mcore_mem_acc_resp_tracker_if
    import plab5_mcore_mem_acc_resp_tracker_pkg::*;
#(
    parameter int unsigned p_ctl_nbits  = mem_req_cnbits(8, 32, 32),
    parameter int unsigned p_data_nbits = 32
) ();

    logic [p_ctl_nbits-1:0]  control;
    logic [p_data_nbits-1:0] data;
    logic                    val;
    logic                    rdy;

    modport master (output control, output data, output val, input  rdy);
    modport slave  (input  control, input  data, input  val, output rdy);

endinterface

// File: rtl/plab5_mcore_mem_acc_tag_queue.sv
// In-order circular buffer of outstanding-request tags with a
// combinational head read; enqueue is ignored when full, dequeue when empty.
module plab5_mcore_mem_acc_tag_queue #(
    parameter int unsigned p_entry_nbits = 15,
    parameter int unsigned p_num_entries = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enq_val,
    input  logic [p_entry_nbits-1:0] enq_data,
    input  logic                     deq_val,
    output logic [p_entry_nbits-1:0] head_data,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned PTR_NBITS = $clog2(p_num_entries);
    localparam int unsigned CNT_NBITS = PTR_NBITS + 1;
    localparam logic [CNT_NBITS-1:0] CNT_FULL = CNT_NBITS'(p_num_entries);

    logic [p_entry_nbits-1:0] entries_q [p_num_entries];
    logic [PTR_NBITS-1:0]     wptr_q, wptr_d;
    logic [PTR_NBITS-1:0]     rptr_q, rptr_d;
    logic [CNT_NBITS-1:0]     count_q, count_d;
    logic                     do_enq;
    logic                     do_deq;

    assign full   = (count_q == CNT_FULL);
    assign empty  = (count_q == '0);
    assign do_enq = enq_val & ~full;
    assign do_deq = deq_val & ~empty;

    assign head_data = entries_q[rptr_q];

    // Depth is a power of two, so pointer wrap is plain binary overflow.
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (do_enq) begin
            wptr_d = wptr_q + PTR_NBITS'(1);
        end
        if (do_deq) begin
            rptr_d = rptr_q + PTR_NBITS'(1);
        end
        case ({do_enq, do_deq})
            2'b10:   count_d = count_q + CNT_NBITS'(1);
            2'b01:   count_d = count_q - CNT_NBITS'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_enq) begin
            entries_q[wptr_q] <= enq_data;
        end
    end

endmodule

// File: rtl/plab5_mcore_mem_acc_resp_tracker.sv
// Forwards permitted requests to memory, answers denied ones locally with
// zero data, and returns exactly one response per request in arrival order.
module plab5_mcore_mem_acc_resp_tracker
    import plab5_mcore_mem_acc_resp_tracker_pkg::*;
#(
    parameter int unsigned p_opaque_nbits = 8,
    parameter int unsigned p_addr_nbits   = 32,
    parameter int unsigned p_data_nbits   = 32,
    parameter int unsigned p_num_entries  = 4,
    parameter int unsigned p_cnt_nbits    = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   req_sec_level,
    input  logic                   mem_sec_level,
    plab5_mcore_mem_acc_resp_tracker_if.slave  net_req,
    plab5_mcore_mem_acc_resp_tracker_if.master mem_req,
    plab5_mcore_mem_acc_resp_tracker_if.slave  mem_resp,
    plab5_mcore_mem_acc_resp_tracker_if.master net_resp,
    output logic                   net_resp_sec_level,
    output logic [p_cnt_nbits-1:0] denied_count,
    output logic                   order_err
);

    localparam int unsigned LEN_NBITS   = mem_len_nbits(p_data_nbits);
    localparam int unsigned REQ_CN      = mem_req_cnbits(p_opaque_nbits, p_addr_nbits, p_data_nbits);
    localparam int unsigned RESP_CN     = mem_resp_cnbits(p_opaque_nbits, p_data_nbits);
    localparam int unsigned ENTRY_NBITS = trk_entry_nbits(p_opaque_nbits, p_data_nbits);
    localparam int unsigned REQ_OPQ_MSB  = REQ_CN - MEM_TYPE_NBITS - 1;
    localparam int unsigned RESP_OPQ_MSB = RESP_CN - MEM_TYPE_NBITS - 1;

    logic                      deny;
    logic                      q_full;
    logic                      q_empty;
    logic                      push;
    logic                      pop;
    logic                      opq_mismatch;
    logic [ENTRY_NBITS-1:0]    enq_entry;
    logic [ENTRY_NBITS-1:0]    head_entry;
    logic                      head_deny;
    logic                      head_sec;
    logic [RESP_CN-1:0]        head_ctl;
    logic [MEM_TYPE_NBITS-1:0] req_type;
    logic [p_opaque_nbits-1:0] req_opaque;
    logic [LEN_NBITS-1:0]      req_len;
    logic [p_opaque_nbits-1:0] head_opaque;
    logic [p_opaque_nbits-1:0] mem_resp_opaque;
    logic [p_cnt_nbits-1:0]    denied_q, denied_d;
    logic                      order_err_q, order_err_d;

    // Non-secure requester touching secure memory is the only denied case.
    assign deny = ~req_sec_level & mem_sec_level;

    assign mem_req.control = net_req.control;
    assign mem_req.data    = net_req.data;
    assign mem_req.val     = net_req.val & ~deny & ~q_full;
    assign net_req.rdy     = ~q_full & (deny | mem_req.rdy);
    assign push            = net_req.val & net_req.rdy;

    assign req_type   = net_req.control[REQ_CN-1 -: MEM_TYPE_NBITS];
    assign req_opaque = net_req.control[REQ_OPQ_MSB -: p_opaque_nbits];
    assign req_len    = net_req.control[LEN_NBITS-1:0];
    assign enq_entry  = {deny, req_sec_level, req_type, req_opaque, req_len};

    plab5_mcore_mem_acc_tag_queue #(
        .p_entry_nbits (ENTRY_NBITS),
        .p_num_entries (p_num_entries)
    ) u_tag_queue (
        .clk       (clk),
        .reset     (reset),
        .enq_val   (push),
        .enq_data  (enq_entry),
        .deq_val   (pop),
        .head_data (head_entry),
        .full      (q_full),
        .empty     (q_empty)
    );

    assign head_deny       = head_entry[ENTRY_NBITS-1];
    assign head_sec        = head_entry[ENTRY_NBITS-2];
    assign head_ctl        = head_entry[RESP_CN-1:0];
    assign head_opaque     = head_ctl[RESP_OPQ_MSB -: p_opaque_nbits];
    assign mem_resp_opaque = mem_resp.control[RESP_OPQ_MSB -: p_opaque_nbits];

    // Empty keeps every response output at zero so stale memory responses
    // are never accepted after a reset.
    always_comb begin
        net_resp.val     = 1'b0;
        net_resp.control = '0;
        net_resp.data    = '0;
        mem_resp.rdy     = 1'b0;
        pop              = 1'b0;
        opq_mismatch     = 1'b0;
        if (!q_empty) begin
            if (head_deny) begin
                net_resp.val     = 1'b1;
                net_resp.control = head_ctl;
                pop              = net_resp.rdy;
            end else begin
                net_resp.val     = mem_resp.val;
                net_resp.control = mem_resp.control;
                net_resp.data    = mem_resp.data;
                mem_resp.rdy     = net_resp.rdy;
                pop              = mem_resp.val & net_resp.rdy;
                opq_mismatch     = pop & (mem_resp_opaque != head_opaque);
            end
        end
    end

    assign net_resp_sec_level = ~q_empty & head_sec;

    always_comb begin
        denied_d = denied_q;
        if (push && deny && (denied_q != '1)) begin
            denied_d = denied_q + p_cnt_nbits'(1);
        end
        order_err_d = order_err_q | opq_mismatch;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            denied_q    <= '0;
            order_err_q <= 1'b0;
        end else begin
            denied_q    <= denied_d;
            order_err_q <= order_err_d;
        end
    end

    assign denied_count = denied_q;
    assign order_err    = order_err_q;

endmodule
